// File: rtl/output_buffer_sequencer_pkg.sv
// Shared types and sizing helpers for the output buffer sequencer.
// Beat count per block and counter widths derive from block parameters.
package output_buffer_sequencer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DEF_PACKET_SIZE   = 8;
  localparam int DEF_MYBUFFER_SIZE = 40;

  // Stream beats needed to carry one block.
  function automatic int beats_f(input int mb, input int ps);
    return (mb + ps - 1) / ps;
  endfunction

  // Bits to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/output_buffer_sequencer_if.sv
// Upscaler handshake, output buffer word and monitored stream signals.
// The sequencer sits on the slave side; the environment on master.
interface output_buffer_sequencer_if #(
  parameter int W = 40
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] buf_data;
  logic         buf_valid;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (
    output in_data, in_valid, tvalid, tready, tlast,
    input  in_ready, buf_data, buf_valid
  );

  modport slave (
    input  in_data, in_valid, tvalid, tready, tlast,
    output in_ready, buf_data, buf_valid
  );
endinterface

// File: rtl/output_buffer_sequencer_monitor.sv
// Watches the output stream while a block is presented: counts beats,
// finds the final handshake, flags wrong length and stalled streams.
module output_stream_monitor #(
  parameter int BEATS   = 5,
  parameter int TIMEOUT = 1024,
  parameter int BW      = 3,
  parameter int WW      = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tvalid_i,
  input  logic          tready_i,
  input  logic          tlast_i,
  input  logic          active_i,
  output logic [BW-1:0] beat_cnt_o,
  output logic          last_hs_o,
  output logic          len_err_o,
  output logic          stall_err_o
);

  logic          beat;
  logic [BW-1:0] beat_cnt_q;
  logic [WW-1:0] wd_q;
  logic          len_err_q;
  logic          stall_err_q;

  assign beat        = tvalid_i & tready_i;
  assign last_hs_o   = active_i & beat & tlast_i;
  assign beat_cnt_o  = beat_cnt_q;
  assign len_err_o   = len_err_q;
  assign stall_err_o = stall_err_q;

  // Beats of the current block; saturates so overlong blocks stay wrong.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (!active_i || last_hs_o) begin
      beat_cnt_q <= '0;
    end else if (beat && beat_cnt_q != BW'(BEATS)) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  // Sticky: final handshake arrived on the wrong beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_err_q <= 1'b0;
    end else if (last_hs_o && beat_cnt_q != BW'(BEATS - 1)) begin
      len_err_q <= 1'b1;
    end
  end

  // Idle-cycle watchdog while presenting; any beat restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (!active_i || beat) begin
      wd_q <= '0;
    end else if (wd_q != WW'(TIMEOUT)) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // Sticky: watchdog reached its limit; the block keeps waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_err_q <= 1'b0;
    end else if (active_i && !beat && wd_q == WW'(TIMEOUT - 1)) begin
      stall_err_q <= 1'b1;
    end
  end

endmodule

// File: rtl/output_buffer_sequencer.sv
// Captures one upscaler block at a time, holds it for the output buffer
// until the stream's final beat, and tracks blocks and frames.
import output_buffer_sequencer_pkg::*;

module output_buffer_sequencer #(
  parameter int PACKET_SIZE      = 8,
  parameter int NROWS            = 2,
  parameter int ROW_LENGTH       = 20,
  parameter int MYBUFFER_SIZE    = 40,
  parameter int BLOCKS_PER_FRAME = 4,
  parameter int TIMEOUT          = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  output_buffer_sequencer_if.slave bus,
  output logic        sof,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        len_err,
  output logic        stall_err
);

  localparam int BEATS = beats_f(MYBUFFER_SIZE, PACKET_SIZE);
  localparam int BW    = cnt_w(BEATS + 1);
  localparam int KW    = cnt_w(BLOCKS_PER_FRAME);
  localparam int WW    = cnt_w(TIMEOUT + 1);

  if (MYBUFFER_SIZE != NROWS * ROW_LENGTH) begin : g_bad_geom
    $error("MYBUFFER_SIZE must equal NROWS*ROW_LENGTH");
  end

  state_t                   state_q;
  logic [MYBUFFER_SIZE-1:0] buf_data_q;
  logic                     buf_valid_q;
  logic [KW-1:0]            block_cnt_q;
  logic                     frame_done_q;
  logic [15:0]              frame_cnt_q;
  logic [BW-1:0]            beat_cnt;
  logic                     last_hs;
  logic                     in_ready;
  logic                     unused_beat_cnt;

  assign in_ready        = !areset && state_q == IDLE && enable;
  assign bus.in_ready    = in_ready;
  assign bus.buf_data    = buf_data_q;
  assign bus.buf_valid   = buf_valid_q;
  assign sof             = buf_valid_q && block_cnt_q == '0;
  assign frame_done      = frame_done_q;
  assign frame_cnt       = frame_cnt_q;
  assign unused_beat_cnt = ^beat_cnt;

  output_stream_monitor #(
    .BEATS   (BEATS),
    .TIMEOUT (TIMEOUT),
    .BW      (BW),
    .WW      (WW)
  ) u_mon (
    .clk         (aclk),
    .rst         (areset),
    .tvalid_i    (bus.tvalid),
    .tready_i    (bus.tready),
    .tlast_i     (bus.tlast),
    .active_i    (state_q == ACTIVE),
    .beat_cnt_o  (beat_cnt),
    .last_hs_o   (last_hs),
    .len_err_o   (len_err),
    .stall_err_o (stall_err)
  );

  // Capture/present FSM with block and frame bookkeeping.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      buf_data_q   <= '0;
      buf_valid_q  <= 1'b0;
      block_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready) begin
            buf_data_q  <= bus.in_data;
            buf_valid_q <= 1'b1;
            state_q     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (last_hs) begin
            buf_valid_q <= 1'b0;
            state_q     <= IDLE;
            if (block_cnt_q == KW'(BLOCKS_PER_FRAME - 1)) begin
              block_cnt_q  <= '0;
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 1'b1;
            end else begin
              block_cnt_q <= block_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_buffer_sequencer.sv
// Randomized bench for output_buffer_sequencer against a block-level
// model: block index, completed frames and sticky flags.
module tb_output_buffer_sequencer;

  localparam int BPF = 2;
  localparam int TO  = 16;
  localparam int NB  = (40 + 8 - 1) / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        sof;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        len_err;
  logic        stall_err;

  int vectors = 0;
  int miscompares = 0;

  int m_blk = 0;
  int m_frames = 0;
  bit m_len = 0;
  bit m_stall = 0;

  output_buffer_sequencer_if #(.W(40)) bus ();

  output_buffer_sequencer #(
    .PACKET_SIZE      (8),
    .NROWS            (2),
    .ROW_LENGTH       (20),
    .MYBUFFER_SIZE    (40),
    .BLOCKS_PER_FRAME (BPF),
    .TIMEOUT          (TO)
  ) dut (
    .aclk       (clk),
    .areset     (rst),
    .enable     (en),
    .bus        (bus.slave),
    .sof        (sof),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .len_err    (len_err),
    .stall_err  (stall_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet;
    bus.in_valid = 1'b0;
    bus.tvalid   = 1'b0;
    bus.tready   = 1'b0;
    bus.tlast    = 1'b0;
  endtask

  task automatic send_block(input logic [39:0] d, input int nb,
                            input int stall_at, input int stall_len,
                            input bit en_drop);
    bit exp_sof;
    bit fd;
    exp_sof = (m_blk == 0);
    en = 1'b1;
    bus.in_data = d;
    bus.in_valid = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_in_ready got %b want 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.in_data = {8'($urandom), $urandom};
    #1;
    vectors++;
    if (bus.buf_valid !== 1'b1 || bus.buf_data !== d) begin
      miscompares++;
      $display("FAIL capture got v=%b d=%h want v=1 d=%h",
               bus.buf_valid, bus.buf_data, d);
    end
    vectors++;
    if (sof !== exp_sof || frame_done !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL present_flags got sof=%b fd=%b rdy=%b want sof=%b fd=0 rdy=0",
               sof, frame_done, bus.in_ready, exp_sof);
    end
    for (int b = 1; b <= nb; b++) begin
      if (b == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.tvalid = 1'($urandom);
          bus.tready = 1'b0;
          bus.tlast  = 1'($urandom);
          if (en_drop) en = 1'b0;
          step();
          vectors++;
          if (bus.buf_data !== d || bus.buf_valid !== 1'b1 ||
              bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                     bus.buf_valid, bus.buf_data, bus.in_ready, d);
          end
          vectors++;
          if (stall_err !== (m_stall || (s + 1) >= TO)) begin
            miscompares++;
            $display("FAIL watchdog cyc=%0d got %b want %b", s + 1,
                     stall_err, (m_stall || (s + 1) >= TO));
          end
        end
      end
      bus.tvalid = 1'b1;
      bus.tready = 1'b1;
      bus.tlast  = (b == nb);
      step();
      if (b < nb) begin
        vectors++;
        if (bus.buf_valid !== 1'b1 || bus.buf_data !== d) begin
          miscompares++;
          $display("FAIL mid_block beat=%0d got v=%b d=%h want v=1 d=%h",
                   b, bus.buf_valid, bus.buf_data, d);
        end
      end
    end
    if (nb != NB) m_len = 1'b1;
    if (stall_len >= TO) m_stall = 1'b1;
    fd = (m_blk == BPF - 1);
    if (fd) begin
      m_frames++;
      m_blk = 0;
    end else begin
      m_blk++;
    end
    quiet();
    en = 1'b1;
    #1;
    vectors++;
    if (bus.buf_valid !== 1'b0 || sof !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL drain got v=%b sof=%b rdy=%b want v=0 sof=0 rdy=1",
               bus.buf_valid, sof, bus.in_ready);
    end
    vectors++;
    if (frame_done !== fd || frame_cnt !== 16'(m_frames)) begin
      miscompares++;
      $display("FAIL frame got fd=%b cnt=%0d want fd=%b cnt=%0d",
               frame_done, frame_cnt, fd, m_frames);
    end
    vectors++;
    if (len_err !== m_len || stall_err !== m_stall) begin
      miscompares++;
      $display("FAIL sticky got len=%b stall=%b want len=%b stall=%b",
               len_err, stall_err, m_len, m_stall);
    end
  endtask

  task automatic test_reset;
    quiet();
    en = 1'b1;
    bus.in_data = 40'h0;
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.buf_valid !== 1'b0 ||
        bus.buf_data !== 40'h0) begin
      miscompares++;
      $display("FAIL reset_bus got rdy=%b v=%b d=%h want 0 0 0",
               bus.in_ready, bus.buf_valid, bus.buf_data);
    end
    vectors++;
    if (sof !== 1'b0 || frame_done !== 1'b0 || frame_cnt !== 16'd0 ||
        len_err !== 1'b0 || stall_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got sof=%b fd=%b cnt=%0d len=%b stall=%b want all 0",
               sof, frame_done, frame_cnt, len_err, stall_err);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single;
    send_block(40'h1234FABCD0, NB, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    send_block(40'hA5A5_0F0F_33, NB, 3, 2, 1'b1);
  endtask

  task automatic test_back_to_back;
    send_block({8'($urandom), $urandom}, NB, 0, 0, 1'b0);
    send_block({8'($urandom), $urandom}, NB, 0, 0, 1'b0);
  endtask

  task automatic test_idle_beats;
    for (int i = 0; i < 4; i++) begin
      en = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = {8'($urandom), $urandom};
      bus.tvalid = 1'b1;
      bus.tready = 1'b1;
      bus.tlast = 1'($urandom);
      step();
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.buf_valid !== 1'b0 ||
          frame_cnt !== 16'(m_frames) || len_err !== m_len ||
          frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_ignore got rdy=%b v=%b cnt=%0d len=%b fd=%b want 0 0 %0d %b 0",
                 bus.in_ready, bus.buf_valid, frame_cnt, len_err,
                 frame_done, m_frames, m_len);
      end
    end
    quiet();
    en = 1'b1;
    step();
  endtask

  task automatic test_len_err;
    send_block({8'($urandom), $urandom}, 3, 0, 0, 1'b0);
    send_block({8'($urandom), $urandom}, NB, 0, 0, 1'b0);
  endtask

  task automatic test_stall;
    send_block({8'($urandom), $urandom}, NB, 1, 20, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [39:0] d;
    d = {8'($urandom), $urandom};
    en = 1'b1;
    bus.in_data = d;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.tvalid = 1'b1;
    bus.tready = 1'b1;
    step();
    step();
    bus.tvalid = 1'b0;
    bus.tready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.buf_valid !== 1'b0 || bus.buf_data !== 40'h0 ||
        bus.in_ready !== 1'b0 || sof !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_bus got v=%b d=%h rdy=%b sof=%b want 0",
               bus.buf_valid, bus.buf_data, bus.in_ready, sof);
    end
    vectors++;
    if (frame_cnt !== 16'd0 || len_err !== 1'b0 || stall_err !== 1'b0 ||
        frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_flags got cnt=%0d len=%b stall=%b fd=%b want 0",
               frame_cnt, len_err, stall_err, frame_done);
    end
    m_blk = 0;
    m_frames = 0;
    m_len = 1'b0;
    m_stall = 1'b0;
    step();
    rst = 1'b0;
    step();
    send_block({8'($urandom), $urandom}, NB, 0, 0, 1'b0);
  endtask

  task automatic test_random;
    int nb;
    int sa;
    int gap;
    for (int i = 0; i < 24; i++) begin
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : NB;
      sa = $urandom_range(0, nb);
      send_block({8'($urandom), $urandom}, nb, sa,
                 $urandom_range(0, 4), 1'($urandom));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus.tvalid = 1'($urandom);
        bus.tready = 1'($urandom);
        bus.tlast = 1'($urandom);
        step();
        vectors++;
        if (bus.buf_valid !== 1'b0 || len_err !== m_len) begin
          miscompares++;
          $display("FAIL gap got v=%b len=%b want v=0 len=%b",
                   bus.buf_valid, len_err, m_len);
        end
      end
      quiet();
    end
  endtask

  initial begin
    quiet();
    bus.in_data = 40'h0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_idle_beats();
    test_len_err();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
